// File: rtl/vsq_quantizer_if.sv
// vsq_quantizer_if: one ready/valid stream carrying a W-bit word.
// The quantizer uses one instance for its vector input and one for its
// result output. The producer side takes the master modport and the
// consumer side takes the slave modport.
interface vsq_quantizer_if #(
    parameter int W = 8
) ();
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/vsq_quantizer.sv
// vsq_quantizer: per-vector power-of-two requantizer.
// The block takes 16 unsigned 18-bit lanes. It finds the lane maximum and
// picks a shift that brings the maximum into 8 bits. Each lane is then
// shifted, rounded half-up and saturated to 8 bits. The result word carries
// the 16 lanes plus the shift exponent.
// There are three register stages (S1 lanes+max, S2 lanes+shift, S3 output)
// and a single global advance enable. 'done' pulses once per VEC_COUNT
// output handshakes.
module vsq_quantizer #(
    parameter int NUM_LANES = 16,
    parameter int IN_W      = 18,
    parameter int OUT_W     = 8,
    parameter int VEC_COUNT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    vsq_quantizer_if.slave  in_if,
    vsq_quantizer_if.master out_if,
    output logic            done
);

    localparam int IN_DW     = 296;
    localparam int OUT_DW    = 136;
    localparam int LANE_BITS = NUM_LANES * IN_W;
    localparam int SH_W      = 4;
    localparam int IDX_W     = $clog2(IN_W);
    localparam int LVLS      = $clog2(NUM_LANES);
    localparam int CNT_W     = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_COUNT - 1);
    localparam logic [IN_W:0]    SAT_LIM  = (IN_W + 1)'((1 << OUT_W) - 1);

    typedef logic [NUM_LANES-1:0][IN_W-1:0] lanes_t;

    // Maximum over all lanes, as a balanced pairwise reduction tree.
    // Level l folds pairs (2k, 2k+1) into slot k. Slots are overwritten in
    // increasing k order, so no slot is overwritten before it is read.
    function automatic logic [IN_W-1:0] tree_max(input lanes_t lanes);
        lanes_t t;
        t = lanes;
        for (int l = 0; l < LVLS; l++) begin
            for (int k = 0; k < NUM_LANES / 2; k++) begin
                if (k < (NUM_LANES >> (l + 1))) begin
                    if (t[2*k+1] > t[2*k]) begin
                        t[k] = t[2*k+1];
                    end else begin
                        t[k] = t[2*k];
                    end
                end else begin
                    t[k] = t[k];
                end
            end
        end
        return t[0];
    endfunction

    // Shift amount: the bit position of the MSB of m, minus (OUT_W-1).
    // It is zero when the maximum already fits in OUT_W bits, including m == 0.
    function automatic logic [SH_W-1:0] shift_of(input logic [IN_W-1:0] m);
        logic [SH_W-1:0] sh;
        sh = '0;
        for (int b = OUT_W; b < IN_W; b++) begin
            if (m[b]) begin
                sh = SH_W'(b - OUT_W + 1);
            end else begin
                sh = sh;
            end
        end
        return sh;
    endfunction

    // Shift right by sh, then add the last bit shifted out (round half up).
    // The sum gets one extra bit so that an overflow past 255 stays
    // visible, and the result saturates at the 8-bit maximum.
    function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] lane,
                                                 input logic [SH_W-1:0] sh);
        logic             rnd;
        logic [IDX_W-1:0] idx;
        logic [IN_W-1:0]  trunc;
        logic [IN_W:0]    r;
        logic [OUT_W-1:0] res;
        trunc = lane >> sh;
        idx   = IDX_W'(sh) - IDX_W'(1);
        if (sh == '0) begin
            rnd = 1'b0;
        end else begin
            rnd = lane[idx];
        end
        r = {1'b0, trunc} + {{IN_W{1'b0}}, rnd};
        if (r > SAT_LIM) begin
            res = {OUT_W{1'b1}};
        end else begin
            res = r[OUT_W-1:0];
        end
        return res;
    endfunction

    // Pipeline state
    logic              s1_valid_q, s1_valid_d;
    lanes_t            s1_lanes_q, s1_lanes_d;
    logic [IN_W-1:0]   s1_max_q,   s1_max_d;
    logic              s2_valid_q, s2_valid_d;
    lanes_t            s2_lanes_q, s2_lanes_d;
    logic [SH_W-1:0]   s2_sh_q,    s2_sh_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_DW-1:0] out_data_q,  out_data_d;

    // Tile counter and done pulse
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              en_s;
    logic              out_hs_s;
    logic              unused_hdr_s;

    // The top byte of the input word is padding and carries no lane data.
    assign unused_hdr_s = ^in_if.data[IN_DW-1:LANE_BITS];

    // Global advance: the whole pipe moves when the output slot is free or drains.
    assign en_s     = !out_valid_q || out_if.ready;
    assign out_hs_s = out_valid_q && out_if.ready;

    assign in_if.ready  = en_s;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign done         = done_q;

    // Next-state for the three pipeline stages; every stage holds while stalled.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lanes_d  = s1_lanes_q;
        s1_max_d    = s1_max_q;
        s2_valid_d  = s2_valid_q;
        s2_lanes_d  = s2_lanes_q;
        s2_sh_d     = s2_sh_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (en_s) begin
            s1_valid_d  = in_if.valid;
            s1_lanes_d  = in_if.data[LANE_BITS-1:0];
            s1_max_d    = tree_max(in_if.data[LANE_BITS-1:0]);
            s2_valid_d  = s1_valid_q;
            s2_lanes_d  = s1_lanes_q;
            s2_sh_d     = shift_of(s1_max_q);
            out_valid_d = s2_valid_q;
            for (int j = 0; j < NUM_LANES; j++) begin
                out_data_d[j*OUT_W +: OUT_W] = requant(s2_lanes_q[j], s2_sh_q);
            end
            out_data_d[OUT_DW-1 -: 8] = {4'b0000, s2_sh_q};
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Count output handshakes; the last one in a tile wraps the count and arms done.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (out_hs_s) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset that drops all in-flight vectors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lanes_q  <= '0;
            s1_max_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_lanes_q  <= '0;
            s2_sh_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lanes_q  <= s1_lanes_d;
            s1_max_q    <= s1_max_d;
            s2_valid_q  <= s2_valid_d;
            s2_lanes_q  <= s2_lanes_d;
            s2_sh_q     <= s2_sh_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_vsq_quantizer.sv
// tb_vsq_quantizer: directed vectors with hand-computed results.
// The driver pushes each expected word at its input handshake. A separate
// negedge monitor pops a word at every output handshake and compares it.
// The monitor also checks the done pulse against its own tile count and
// checks that the output stays stable while stalled.
module tb_vsq_quantizer;

    logic clk;
    logic rst_n;
    logic done;

    int checks;
    int errors;
    int done_pulses;
    logic in_ready_low_seen;
    logic [135:0] exp_q[$];

    vsq_quantizer_if #(.W(296)) in_if ();
    vsq_quantizer_if #(.W(136)) out_if ();

    vsq_quantizer #(
        .NUM_LANES (16),
        .IN_W      (18),
        .OUT_W     (8),
        .VEC_COUNT (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (in_if),
        .out_if (out_if),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [295:0] mk_in(input logic [15:0][17:0] l, input logic [7:0] pad);
        return {pad, l};
    endfunction

    function automatic logic [135:0] mk_exp(input logic [15:0][7:0] l, input logic [3:0] sh);
        return {4'b0000, sh, l};
    endfunction

    // Present one vector; push its expected result once it is accepted.
    task automatic send(input logic [295:0] d, input logic [135:0] e);
        int waited;
        waited = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        @(negedge clk);
        while (!in_if.ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_if.ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waited);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then realign just after a posedge.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Send count vectors in which lane j = base+i+8*j. All values stay below 256,
    // so sh = 0 and each result lane equals its input lane.
    task automatic stream(input int base, input int count, input bit bubbles);
        logic [15:0][17:0] li;
        logic [15:0][7:0]  lo;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < 16; j++) begin
                li[j] = 18'(base + i + j * 8);
                lo[j] = 8'(base + i + j * 8);
            end
            send(mk_in(li, 8'h00), mk_exp(lo, 4'd0));
            if (bubbles && (i % 5 == 4)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Scoreboard monitor, plus a done model and a stall-stability check.
    initial begin : monitor
        int           cnt_m;
        logic         exp_done_nxt;
        logic         prev_stall;
        logic [135:0] prev_data;
        logic [135:0] e;
        cnt_m        = 0;
        exp_done_nxt = 1'b0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                cnt_m        = 0;
                exp_done_nxt = 1'b0;
                prev_stall   = 1'b0;
                done_pulses  = 0;
            end else begin
                chk("done", {135'd0, done}, {135'd0, exp_done_nxt});
                if (done) done_pulses++;
                chk("in_ready", {135'd0, in_if.ready}, {135'd0, (!out_if.valid || out_if.ready)});
                if (!in_if.ready) in_ready_low_seen = 1'b1;
                if (prev_stall) begin
                    chk("stall_valid", {135'd0, out_if.valid}, {135'd0, 1'b1});
                    chk("stall_data", out_if.data, prev_data);
                end
                exp_done_nxt = 1'b0;
                if (out_if.valid && out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %h expected no output", out_if.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_if.data, e);
                    end
                    if (cnt_m == 15) begin
                        cnt_m        = 0;
                        exp_done_nxt = 1'b1;
                    end else begin
                        cnt_m++;
                    end
                end
                prev_stall = out_if.valid && !out_if.ready;
                prev_data  = out_if.data;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0][17:0] li;
        logic [15:0][7:0]  lo;
        int n;
        checks            = 0;
        errors            = 0;
        done_pulses       = 0;
        in_ready_low_seen = 1'b0;
        rst_n             = 1'b0;
        in_if.valid       = 1'b0;
        in_if.data        = '0;
        out_if.ready      = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {135'd0, out_if.valid}, 136'd0);
        chk("rst_out_data", out_if.data, 136'd0);
        chk("rst_done", {135'd0, done}, 136'd0);
        chk("rst_in_ready", {135'd0, in_if.ready}, {135'd0, 1'b1});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All lanes 100 -> 0x64, sh 0, visible three edges after presentation
        for (int j = 0; j < 16; j++) begin li[j] = 18'd100; lo[j] = 8'h64; end
        send(mk_in(li, 8'h00), mk_exp(lo, 4'd0));
        @(negedge clk);
        chk("lat_s1", {135'd0, out_if.valid}, 136'd0);
        @(negedge clk);
        chk("lat_s2", {135'd0, out_if.valid}, 136'd0);
        @(negedge clk);
        chk("lat_s3", {135'd0, out_if.valid}, {135'd0, 1'b1});
        drain();

        // Lane0 = 0x3FFFF, others 1000 -> sh 10, lane0 saturates, others round to 1
        for (int j = 0; j < 16; j++) begin li[j] = 18'd1000; lo[j] = 8'd1; end
        li[0] = 18'h3FFFF; lo[0] = 8'd255;
        send(mk_in(li, 8'hA5), mk_exp(lo, 4'd10));
        // Lane5 = 511, lane0 = 3 -> sh 1, lane5 = 255, lane0 = 2
        for (int j = 0; j < 16; j++) begin li[j] = 18'd0; lo[j] = 8'd0; end
        li[5] = 18'd511; lo[5] = 8'd255;
        li[0] = 18'd3;   lo[0] = 8'd2;
        send(mk_in(li, 8'h00), mk_exp(lo, 4'd1));
        // All zero -> sh 0, all zero
        for (int j = 0; j < 16; j++) begin li[j] = 18'd0; lo[j] = 8'd0; end
        send(mk_in(li, 8'hFF), mk_exp(lo, 4'd0));
        // Max exactly 255 -> sh 0, lanes pass through
        for (int j = 0; j < 16; j++) begin li[j] = 18'(j * 17); lo[j] = 8'(j * 17); end
        send(mk_in(li, 8'h00), mk_exp(lo, 4'd0));
        // Max 256 -> sh 1: 256->128, 3->2, 1->1
        for (int j = 0; j < 16; j++) begin li[j] = 18'd0; lo[j] = 8'd0; end
        li[3] = 18'd256; lo[3] = 8'd128;
        li[1] = 18'd3;   lo[1] = 8'd2;
        li[2] = 18'd1;   lo[2] = 8'd1;
        send(mk_in(li, 8'h00), mk_exp(lo, 4'd1));
        // Max 4096 -> sh 5: 4096->128, 47->1, 48->2, 31->1, 15->0
        for (int j = 0; j < 16; j++) begin li[j] = 18'd0; lo[j] = 8'd0; end
        li[0] = 18'd4096; lo[0] = 8'd128;
        li[1] = 18'd47;   lo[1] = 8'd1;
        li[2] = 18'd48;   lo[2] = 8'd2;
        li[3] = 18'd31;   lo[3] = 8'd1;
        li[4] = 18'd15;   lo[4] = 8'd0;
        send(mk_in(li, 8'h00), mk_exp(lo, 4'd5));
        drain();

        // Four back-to-back vectors with out_ready low for 5 cycles after first out_valid
        in_ready_low_seen = 1'b0;
        fork
            begin
                stream(40, 4, 1'b0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_if.valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                out_if.ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_if.ready = 1'b1;
            end
        join
        drain();
        chk("stall_in_ready_low", {135'd0, in_ready_low_seen}, {135'd0, 1'b1});

        // Fresh tile: done once after 16 outputs, next one after 32
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(0, 16, 1'b1);
        drain();
        chk("done_count_16", 136'(done_pulses), 136'd1);
        stream(16, 16, 1'b1);
        drain();
        chk("done_count_32", 136'(done_pulses), 136'd2);

        // Counter at 3, two vectors in flight, one-cycle reset
        stream(5, 3, 1'b0);
        drain();
        stream(9, 2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {135'd0, out_if.valid}, 136'd0);
        chk("midrst_done", {135'd0, done}, 136'd0);
        repeat (3) @(negedge clk);
        chk("midrst_flushed", {135'd0, out_if.valid}, 136'd0);
        @(posedge clk);
        #1;
        stream(20, 16, 1'b0);
        drain();
        chk("done_after_reset", 136'(done_pulses), 136'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
